// File: rtl/hex_pkg.sv
// Shared 7-segment glyph definitions (active-low, bit order gfedcba) and nibble lookup.
package hex_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0011000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_LC_N  = 7'b0101011;
  localparam seg_t SEG_LC_R  = 7'b0101111;
  localparam seg_t SEG_UC_L  = 7'b1000111;

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    seg_t seg;
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_driver_glyph.sv
// Combinational nibble to active-low 7-segment glyph lookup, one per digit.
module hex_glyph
  import hex_pkg::*;
(
  input  logic [3:0] nibble_i,
  output seg_t       seg_c
);

  always_comb begin
    seg_c = hex_to_seg(nibble_i);
  end

endmodule

// File: rtl/hex_display_driver.sv
// Registered multi-digit 7-segment driver with load strobe, leading-zero blanking
// and per-digit blinking.
module hex_display_driver
  import hex_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned BLINK_DIV  = 12_500_000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_en,
  output logic [7*NUM_DIGITS-1:0] segs,
  output logic                    blink_phase,
  output logic                    updated
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W = 7 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(BLINK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

  logic [VAL_W-1:0] value_q, value_d;
  logic [SEG_W-1:0] segs_q, segs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_phase_q, blink_phase_d;
  logic             pending_q, pending_d;
  logic             updated_q, updated_d;

  seg_t glyph_c [NUM_DIGITS];

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_digit
    hex_glyph u_glyph (
      .nibble_i (value_q[4*g +: 4]),
      .seg_c    (glyph_c[g])
    );
  end

  // Free-running blink divider; load never touches it.
  always_comb begin
    cnt_d         = cnt_q + CNT_W'(1);
    blink_phase_d = blink_phase_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d         = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // pending marks the edge that latched value; updated follows one edge later with segs.
  always_comb begin
    value_d   = load ? value : value_q;
    pending_d = load;
    updated_d = pending_q;
  end

  // Walk from the top digit down; lz_run stays high while every nibble so far is zero.
  always_comb begin
    logic lz_run;
    logic dark;
    segs_d = '0;
    lz_run = 1'b1;
    dark   = 1'b0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      lz_run = lz_run & (value_q[4*i +: 4] == 4'd0);
      dark   = (blink_phase_q & blink_en[i]) | (blank_lz & lz_run & (i != 0));
      segs_d[7*i +: 7] = dark ? SEG_BLANK : glyph_c[i];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      value_q       <= '0;
      segs_q        <= {NUM_DIGITS{SEG_0}};
      cnt_q         <= '0;
      blink_phase_q <= 1'b0;
      pending_q     <= 1'b0;
      updated_q     <= 1'b0;
    end else begin
      value_q       <= value_d;
      segs_q        <= segs_d;
      cnt_q         <= cnt_d;
      blink_phase_q <= blink_phase_d;
      pending_q     <= pending_d;
      updated_q     <= updated_d;
    end
  end

  assign segs        = segs_q;
  assign blink_phase = blink_phase_q;
  assign updated     = updated_q;

endmodule

// File: tb/tb_hex_display_driver.sv
// Directed self-checking bench for hex_display_driver with a short blink divider.
module tb_hex_display_driver;

  localparam int unsigned ND = 4;

  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001;
  localparam logic [6:0] G5 = 7'b0010010;
  localparam logic [6:0] G6 = 7'b0000010;
  localparam logic [6:0] G7 = 7'b1111000;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] GA = 7'b0001000;
  localparam logic [6:0] GF = 7'b0001110;
  localparam logic [6:0] GX = 7'b1111111;

  logic            clock;
  logic            resetn;
  logic [4*ND-1:0] value;
  logic            load;
  logic            blank_lz;
  logic [ND-1:0]   blink_en;
  logic [7*ND-1:0] segs;
  logic            blink_phase;
  logic            updated;

  int checks;
  int failures;

  hex_display_driver #(
    .NUM_DIGITS (ND),
    .BLINK_DIV  (4)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .value       (value),
    .load        (load),
    .blank_lz    (blank_lz),
    .blink_en    (blink_en),
    .segs        (segs),
    .blink_phase (blink_phase),
    .updated     (updated)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b1;
    value    = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    blink_en = '0;
    #1;

    // Reset held: load must be ignored
    resetn = 1'b0;
    value  = 16'hFFFF;
    load   = 1'b1;
    step(); step(); step();
    check("rst_segs",    32'(segs),        32'({G0, G0, G0, G0}));
    check("rst_updated", 32'(updated),     32'd0);
    check("rst_phase",   32'(blink_phase), 32'd0);
    load   = 1'b0;
    resetn = 1'b1;
    step();
    check("rel_segs",    32'(segs),    32'({G0, G0, G0, G0}));
    check("rel_updated", 32'(updated), 32'd0);

    // Load latency: edge k latches, edge k+1 shows, pulse lasts one cycle
    value = 16'h12AF;
    load  = 1'b1;
    step();
    load = 1'b0;
    check("ld_k_segs",    32'(segs),    32'({G0, G0, G0, G0}));
    check("ld_k_updated", 32'(updated), 32'd0);
    step();
    check("ld_k1_segs",    32'(segs),    32'({G1, G2, GA, GF}));
    check("ld_k1_updated", 32'(updated), 32'd1);
    step();
    check("ld_k2_updated", 32'(updated), 32'd0);
    check("ld_k2_segs",    32'(segs),    32'({G1, G2, GA, GF}));

    // Back-to-back loads: two pulses, last value wins
    value = 16'h0001;
    load  = 1'b1;
    step();
    value = 16'h0002;
    step();
    load = 1'b0;
    check("b2b_1_segs",    32'(segs),    32'({G0, G0, G0, G1}));
    check("b2b_1_updated", 32'(updated), 32'd1);
    step();
    check("b2b_2_segs",    32'(segs),    32'({G0, G0, G0, G2}));
    check("b2b_2_updated", 32'(updated), 32'd1);
    step();
    check("b2b_3_updated", 32'(updated), 32'd0);

    // Leading-zero blanking
    blank_lz = 1'b1;
    value    = 16'h0040;
    load     = 1'b1;
    step();
    load = 1'b0;
    step();
    check("lz_0040", 32'(segs), 32'({GX, GX, G4, G0}));
    value = 16'h0000;
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    check("lz_0000", 32'(segs), 32'({GX, GX, GX, G0}));
    blank_lz = 1'b0;
    step();
    check("lz_off_live", 32'(segs), 32'({G0, G0, G0, G0}));
    blank_lz = 1'b1;
    value    = 16'h0F00;
    load     = 1'b1;
    step();
    load = 1'b0;
    step();
    check("lz_inner_zero", 32'(segs), 32'({GX, GF, G0, G0}));
    value = 16'h1000;
    load  = 1'b1;
    step();
    load = 1'b0;
    step();
    check("lz_top_set", 32'(segs), 32'({G1, G0, G0, G0}));
    blank_lz = 1'b0;

    // Realign the divider with an async reset pulse between edges
    resetn = 1'b0;
    #2;
    resetn = 1'b1;

    // Blink on digit 1; edges e1.. counted from reset release
    blink_en = 4'b0010;
    value    = 16'h1234;
    load     = 1'b1;
    step(); // e1
    load = 1'b0;
    step(); // e2
    check("bl_e2_segs", 32'(segs), 32'({G1, G2, G3, G4}));
    step(); // e3
    check("bl_e3_phase", 32'(blink_phase), 32'd0);
    step(); // e4 wrap
    check("bl_e4_phase", 32'(blink_phase), 32'd1);
    check("bl_e4_segs",  32'(segs),        32'({G1, G2, G3, G4}));
    step(); // e5
    check("bl_e5_segs", 32'(segs), 32'({G1, G2, GX, G4}));
    step(); step(); // e7
    check("bl_e7_phase", 32'(blink_phase), 32'd1);
    check("bl_e7_segs",  32'(segs),        32'({G1, G2, GX, G4}));
    step(); // e8 wrap
    check("bl_e8_phase", 32'(blink_phase), 32'd0);
    step(); // e9
    check("bl_e9_segs", 32'(segs), 32'({G1, G2, G3, G4}));
    step(); step(); // e11

    // Load on the wrap edge with every digit blinking
    blink_en = 4'hF;
    value    = 16'h5678;
    load     = 1'b1;
    step(); // e12 wrap
    load = 1'b0;
    check("sim_e12_phase",   32'(blink_phase), 32'd1);
    check("sim_e12_segs",    32'(segs),        32'({G1, G2, G3, G4}));
    check("sim_e12_updated", 32'(updated),     32'd0);
    step(); // e13
    check("sim_e13_segs",    32'(segs),    32'({GX, GX, GX, GX}));
    check("sim_e13_updated", 32'(updated), 32'd1);
    step(); step(); // e15
    check("sim_e15_phase", 32'(blink_phase), 32'd1);
    step(); // e16 wrap
    check("sim_e16_phase", 32'(blink_phase), 32'd0);
    step(); // e17
    check("sim_e17_segs", 32'(segs), 32'({G5, G6, G7, G8}));
    step(); step(); step(); // e20 wrap
    check("ar_pre_phase", 32'(blink_phase), 32'd1);

    // Async reset between edges takes effect without a clock
    resetn = 1'b0;
    #2;
    check("ar_phase",   32'(blink_phase), 32'd0);
    check("ar_segs",    32'(segs),        32'({G0, G0, G0, G0}));
    check("ar_updated", 32'(updated),     32'd0);
    step();
    check("ar_hold_segs", 32'(segs), 32'({G0, G0, G0, G0}));
    resetn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
